wb_master: RTL and testbench
============================

# wb_master

Wishbone B4 classic initiator that turns single load/store requests from the core into SINGLE READ / SINGLE WRITE bus cycles. It is the counterpart to the `memory` responder. It generates byte-lane selects and write-data replication from an access size, aligns and extends read data, and handles `err`/`rty` terminations. It sits between the core's load/store (or fetch) path and the shared Wishbone bus.

## Interface
- `MAX_RETRIES`, 3: number of `rty_i` re-issues before the access is reported as an error.
- `TIMEOUT_CYCLES`, 16: cycles with `stb_o` high and no termination before abort. Used only with `WB_MASTER_TIMEOUT_EN`.

Ports:
- `clk_i` in 1: clock; all logic on the rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: master can accept a request.
- `req_addr_i` in 32: byte address.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_size_i` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned_i` in 1: zero-extend load data (otherwise sign-extend).
- `req_wdata_i` in 32: store data, LSB-aligned.
- `rsp_valid_o` out 1: one-cycle response pulse.
- `rsp_err_o` out 1: access failed; qualified by `rsp_valid_o`.
- `rsp_rdata_o` out 32: aligned, extended load data; 0 for stores and errors.
- `cyc_o`, `stb_o` out 1: Wishbone cycle and strobe.
- `adr_o` out 32: word address, bits [1:0] = 0.
- `sel_o` out 4: byte lane select.
- `dat_o` out 32: write data.
- `we_o` out 1: write enable.
- `dat_i` in 32: read data.
- `ack_i`, `err_i`, `rty_i` in 1: cycle terminations.

## Operation
- States are IDLE, BUS, BACKOFF.
- **IDLE**
  - `req_ready_o` = 1.
  - On `req_valid_i`, latch the request.
  - Misaligned or illegal requests produce no bus cycle: `rsp_valid_o`/`rsp_err_o` pulse next cycle and the state stays IDLE. Misaligned means half with addr[0]=1, word with addr[1:0]≠0, or size 11.
  - Otherwise go to BUS.
- **BUS**
  - `cyc_o` = `stb_o` = 1; `adr_o`, `sel_o`, `dat_o`, `we_o` held stable.
  - Termination priority when sampled on an edge: `err_i` > `rty_i` > `ack_i`.
  - `ack_i`: go to IDLE and pulse the response (`rsp_err_o` = 0).
  - `err_i`: go to IDLE and pulse the response (`rsp_err_o` = 1).
  - `rty_i`: if the retry count is below `MAX_RETRIES`, increment it and go to BACKOFF; otherwise error response and go to IDLE.
- **BACKOFF**
  - `cyc_o` = `stb_o` = 0 for exactly one cycle, then back to BUS with identical address, data and selects.
- Lane rules (a = addr[1:0]):
  - `sel_o`: byte = 4'b0001<<a; half = 4'b0011<<a; word = 4'b1111.
  - `dat_o`: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- Read data: `dat_i` >> (8·a), truncated to the access size, then sign- or zero-extended to 32 bits.
- Reset values: all outputs 0 except `req_ready_o` = 1; state IDLE; retry count 0.
- Reset mid-cycle: `cyc_o`/`stb_o` drop asynchronously and no response is produced for the aborted access.

## Timing
- Request accepted at edge E → `cyc_o`/`stb_o` high from E.
- Termination sampled at edge E+k → `cyc_o`/`stb_o` low and `rsp_valid_o` high for the cycle after E+k.
- `req_ready_o` is high in that same response cycle, so a new request may be accepted there (back-to-back).
- With the one-wait-state `memory` responder, k = 1, giving 2 cycles from acceptance to response.
- `ack_i`/`err_i`/`rty_i` are ignored outside BUS.
- Retry costs 2 cycles per attempt (BACKOFF + re-strobe), plus the responder's latency.

## Configuration
- `WB_MASTER_TIMEOUT_EN` defined:
  - A counter runs while in BUS and clears on entry to BUS.
  - Reaching `TIMEOUT_CYCLES` drops `cyc_o`/`stb_o`, pulses `rsp_valid_o` with `rsp_err_o` = 1, and returns to IDLE.
  - A termination on the same edge as the timeout wins.
- Undefined: no counter; BUS waits indefinitely.

## Structure
- `wb_pkg` holds:
  - the size enum (`SIZE_BYTE`/`SIZE_HALF`/`SIZE_WORD`);
  - the state enum;
  - the lane-select and alignment-check functions.
- Sub-module `wb_lane_align` holds the combinational read-data shift/extend and write-data replication. The FSM, retry counter and timeout stay in `wb_master`.

## Test plan
- Word store of 32'h01234567 to 0, then word load from 0 against `memory` → `sel_o` = 4'b1111; response 2 cycles after acceptance; `rsp_rdata_o` = 32'h01234567; `rsp_err_o` = 0.
- Signed byte loads from addresses 0–3 of 32'h01234567 → `sel_o` = 0001, 0010, 0100, 1000; data = 32'h00000067, 32'h00000045, 32'h00000023, 32'h00000001. Unsigned load of 32'h80 byte → 32'h00000080; signed → 32'hFFFFFF80.
- Half store of 16'hBEEF to address 2 → `sel_o` = 4'b1100, `dat_o` = 32'hBEEFBEEF. Half load from address 1 → no `cyc_o`, `rsp_err_o` = 1 next cycle.
- Responder asserts `rty_i` twice then `ack_i` → two one-cycle `cyc_o` gaps, identical `adr_o`, success. Four consecutive `rty_i` with `MAX_RETRIES` = 3 → `rsp_err_o` = 1.
- `err_i` and `ack_i` on the same edge → `rsp_err_o` = 1. `rst_ni` low mid-BUS → `cyc_o` = 0 immediately, no `rsp_valid_o`.
- With `WB_MASTER_TIMEOUT_EN`, a silent responder → error response 16 cycles after `stb_o` rises, then `req_ready_o` = 1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and lane helpers for the Wishbone B4 classic initiator.
package wb_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_BUS     = 2'b01,
    ST_BACKOFF = 2'b10
  } state_e;

  function automatic logic [3:0] lane_sel(input size_e size, input logic [1:0] a);
    case (size)
      SIZE_BYTE: lane_sel = 4'b0001 << a;
      SIZE_HALF: lane_sel = 4'b0011 << a;
      SIZE_WORD: lane_sel = 4'b1111;
      default:   lane_sel = 4'b0000;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e size, input logic [1:0] a);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = a[0];
      SIZE_WORD: is_misaligned = |a;
      default:   is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/wb_lane_align.sv
// Combinational store-data replication and load-data shift/extend.
module wb_lane_align
  import wb_pkg::*;
(
  input  size_e       i_wr_size,
  input  logic [31:0] i_wr_data,
  output logic [31:0] o_wr_data,
  input  size_e       i_rd_size,
  input  logic [1:0]  i_rd_addr_lo,
  input  logic        i_rd_unsigned,
  input  logic [31:0] i_rd_data,
  output logic [31:0] o_rd_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rd_data >> {i_rd_addr_lo, 3'b000};

  always_comb begin
    o_wr_data = i_wr_data;
    case (i_wr_size)
      SIZE_BYTE: o_wr_data = {4{i_wr_data[7:0]}};
      SIZE_HALF: o_wr_data = {2{i_wr_data[15:0]}};
      default:   o_wr_data = i_wr_data;
    endcase
  end

  always_comb begin
    o_rd_data = w_shifted;
    case (i_rd_size)
      SIZE_BYTE: o_rd_data = {{24{~i_rd_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      SIZE_HALF: o_rd_data = {{16{~i_rd_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default:   o_rd_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/wb_master.sv
// Wishbone B4 classic single-access initiator with rty back-off and err handling.
// Optional bus watchdog enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master
  import wb_pkg::*;
#(
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic        rsp_err_o,
  output logic [31:0] rsp_rdata_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic [31:0] adr_o,
  output logic [3:0]  sel_o,
  output logic [31:0] dat_o,
  output logic        we_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i
);

  localparam int unsigned RetryW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  state_e            r_state, w_next;
  logic [31:0]       r_adr, r_dat;
  logic [3:0]        r_sel;
  logic              r_we, r_unsigned;
  size_e             r_size;
  logic [1:0]        r_addr_lo;
  logic [RetryW-1:0] r_retry;
  logic              r_rsp_valid, r_rsp_err;
  logic [31:0]       r_rsp_rdata;

  size_e       w_req_size;
  logic        w_req_bad, w_retry_left, w_timeout;
  logic [31:0] w_wdata_rep, w_rdata_ext;

  assign w_req_size   = size_e'(req_size_i);
  assign w_req_bad    = is_misaligned(w_req_size, req_addr_i[1:0]);
  assign w_retry_left = (r_retry < RetryW'(MAX_RETRIES));

  wb_lane_align u_align (
    .i_wr_size     (w_req_size),
    .i_wr_data     (req_wdata_i),
    .o_wr_data     (w_wdata_rep),
    .i_rd_size     (r_size),
    .i_rd_addr_lo  (r_addr_lo),
    .i_rd_unsigned (r_unsigned),
    .i_rd_data     (dat_i),
    .o_rd_data     (w_rdata_ext)
  );

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] r_tmo;

  // Held at zero outside BUS so every (re-)strobe gets a fresh window
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                r_tmo <= '0;
    else if (r_state != ST_BUS) r_tmo <= '0;
    else                        r_tmo <= r_tmo + 1'b1;
  end

  assign w_timeout = (r_state == ST_BUS) && (r_tmo == TmoW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (req_valid_i && !w_req_bad) w_next = ST_BUS;
      ST_BUS: begin
        if (err_i)                   w_next = ST_IDLE;
        else if (rty_i)              w_next = w_retry_left ? ST_BACKOFF : ST_IDLE;
        else if (ack_i || w_timeout) w_next = ST_IDLE;
      end
      ST_BACKOFF: w_next = ST_BUS;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Response fields pulse for a single cycle; termination priority is err > rty > ack
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_adr       <= '0;
      r_dat       <= '0;
      r_sel       <= '0;
      r_we        <= 1'b0;
      r_unsigned  <= 1'b0;
      r_size      <= SIZE_BYTE;
      r_addr_lo   <= '0;
      r_retry     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid_i) begin
            if (w_req_bad) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else begin
              r_adr      <= {req_addr_i[31:2], 2'b00};
              r_sel      <= lane_sel(w_req_size, req_addr_i[1:0]);
              r_dat      <= w_wdata_rep;
              r_we       <= req_we_i;
              r_size     <= w_req_size;
              r_addr_lo  <= req_addr_i[1:0];
              r_unsigned <= req_unsigned_i;
              r_retry    <= '0;
            end
          end
        end
        ST_BUS: begin
          if (err_i) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
          end else if (rty_i) begin
            if (w_retry_left) begin
              r_retry <= r_retry + 1'b1;
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end
          end else if (ack_i) begin
            r_rsp_valid <= 1'b1;
            if (!r_we) r_rsp_rdata <= w_rdata_ext;
          end else if (w_timeout) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o = (r_state == ST_IDLE);
  assign cyc_o       = (r_state == ST_BUS);
  assign stb_o       = (r_state == ST_BUS);
  assign adr_o       = r_adr;
  assign sel_o       = r_sel;
  assign dat_o       = r_dat;
  assign we_o        = r_we;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_err_o   = r_rsp_err;
  assign rsp_rdata_o = r_rsp_rdata;

endmodule

// File: tb/tb_wb_master.sv
// Self-checking bench for wb_master: directed vector table, hand-written corner
// sequences and randomized accesses checked against a byte-level memory model.
module tb_wb_master;

  localparam int MaxRetries = 3;

  logic        clk_i, rst_ni;
  logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [1:0]  req_size_i;
  logic        rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        cyc_o, stb_o, we_o;
  logic [31:0] adr_o, dat_o, dat_i;
  logic [3:0]  sel_o;
  logic        ack_i, err_i, rty_i;

  wb_master dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o),
    .rsp_rdata_o(rsp_rdata_o), .cyc_o(cyc_o), .stb_o(stb_o), .adr_o(adr_o),
    .sel_o(sel_o), .dat_o(dat_o), .we_o(we_o), .dat_i(dat_i),
    .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] wdata;
    int          nRty;
    bit          doErr;
    int          waits;
  } access_t;

  typedef struct {
    access_t     acc;
    logic        expErr;
    logic [31:0] expRdata;
    logic [3:0]  expSel;
    logic [31:0] expDat;
  } vec_t;

  typedef struct {
    bit          timedOut;
    logic        err;
    logic [31:0] rdata;
    int          cycles;
    bit          busSeen;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] adr;
    logic        we;
    int          gaps;
    bit          unstable;
  } result_t;

  int nVectors = 0;
  int nMiscompares = 0;

  logic [31:0] busMem [0:15];
  logic [7:0]  refMem [0:63];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic access_t mkAcc(input logic [31:0] addr, input bit we, input logic [1:0] size,
                                    input bit uns, input logic [31:0] wdata, input int nRty,
                                    input bit doErr, input int waits);
    access_t a;
    a.addr = addr; a.we = we; a.size = size; a.uns = uns; a.wdata = wdata;
    a.nRty = nRty; a.doErr = doErr; a.waits = waits;
    return a;
  endfunction

  function automatic vec_t mkVec(input access_t a, input logic e, input logic [31:0] rd,
                                 input logic [3:0] s, input logic [31:0] d);
    vec_t v;
    v.acc = a; v.expErr = e; v.expRdata = rd; v.expSel = s; v.expDat = d;
    return v;
  endfunction

  function automatic bit isBad(input access_t a);
    return (a.size == 2'd3) || (a.size == 2'd1 && a.addr % 2 != 0) || (a.size == 2'd2 && a.addr % 4 != 0);
  endfunction

  function automatic int nBytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] refLoad(input access_t a);
    logic [31:0] v = 0;
    int base = int'(a.addr % 64);
    int n = nBytes(a.size);
    for (int i = 0; i < n; i++) v = v + (32'(refMem[base + i]) << (8 * i));
    if (!a.uns && n == 1 && v >= 32'd128)   v = v + 32'hFFFFFF00;
    if (!a.uns && n == 2 && v >= 32'd32768) v = v + 32'hFFFF0000;
    return v;
  endfunction

  function automatic void refStore(input access_t a);
    int base = int'(a.addr % 64);
    for (int i = 0; i < nBytes(a.size); i++) refMem[base + i] = 8'((a.wdata >> (8 * i)) % 256);
  endfunction

  // Drives one request (call right after a negedge) and plays the responder
  task automatic applyStimulus(input access_t a, output result_t r);
    int wcnt = 0;
    int rtyLeft = a.nRty;
    bit done = 0;
    r.timedOut = 0; r.err = 0; r.rdata = 0; r.cycles = 0; r.busSeen = 0;
    r.sel = 0; r.dat = 0; r.adr = 0; r.we = 0; r.gaps = 0; r.unstable = 0;
    checkOutput("req_ready before request", 32'(req_ready_o), 32'd1);
    req_valid_i = 1; req_addr_i = a.addr; req_we_i = a.we; req_size_i = a.size;
    req_unsigned_i = a.uns; req_wdata_i = a.wdata;
    @(posedge clk_i); #1;
    req_valid_i = 0; req_wdata_i = $urandom; req_addr_i = $urandom;
    while (!done && r.cycles < 200) begin
      @(negedge clk_i);
      r.cycles++;
      ack_i = 0; err_i = 0; rty_i = 0; dat_i = $urandom;
      if (rsp_valid_o) begin
        done = 1; r.err = rsp_err_o; r.rdata = rsp_rdata_o;
      end else if (cyc_o) begin
        if (!r.busSeen) begin
          r.busSeen = 1; r.sel = sel_o; r.dat = dat_o; r.adr = adr_o; r.we = we_o;
        end else if (adr_o !== r.adr || sel_o !== r.sel || dat_o !== r.dat || we_o !== r.we) begin
          r.unstable = 1;
        end
        if (stb_o !== 1'b1) r.unstable = 1;
        if (wcnt < a.waits) wcnt++;
        else begin
          wcnt = 0;
          if (rtyLeft > 0) begin
            rty_i = 1; rtyLeft--;
          end else if (a.doErr) begin
            err_i = 1; ack_i = 1;
          end else begin
            ack_i = 1;
            if (we_o) begin
              for (int i = 0; i < 4; i++)
                if (sel_o[i]) busMem[adr_o[5:2]][8*i +: 8] = dat_o[8*i +: 8];
            end else dat_i = busMem[adr_o[5:2]];
          end
        end
      end else if (r.busSeen) r.gaps++;
    end
    r.timedOut = !done;
  endtask

  task automatic runOne(input string tag, input access_t a, input logic expErr,
                        input logic [31:0] expRdata, input logic [3:0] expSel, input logic [31:0] expDat);
    result_t r;
    bit bad = isBad(a);
    bit modelErr = bad || a.doErr || (a.nRty > MaxRetries);
    int attempts = bad ? 0 : ((a.nRty > MaxRetries) ? MaxRetries + 1 : a.nRty + 1);
    int expLat = bad ? 1 : attempts * (a.waits + 2);
    applyStimulus(a, r);
    checkOutput({tag, " response timeout"}, 32'(r.timedOut), 32'd0);
    checkOutput({tag, " rsp_err"}, 32'(r.err), 32'(expErr));
    checkOutput({tag, " rsp_rdata"}, r.rdata, expRdata);
    checkOutput({tag, " latency"}, 32'(r.cycles), 32'(expLat));
    checkOutput({tag, " bus cycle seen"}, 32'(r.busSeen), 32'(!bad));
    if (!bad) begin
      checkOutput({tag, " sel_o"}, 32'(r.sel), 32'(expSel));
      checkOutput({tag, " dat_o"}, r.dat, expDat);
      checkOutput({tag, " adr_o"}, r.adr, a.addr - (a.addr % 4));
      checkOutput({tag, " we_o"}, 32'(r.we), 32'(a.we));
      checkOutput({tag, " backoff gaps"}, 32'(r.gaps), 32'(attempts - 1));
      checkOutput({tag, " bus stable"}, 32'(r.unstable), 32'd0);
    end
    if (!modelErr && a.we) refStore(a);
  endtask

  task automatic checkReset();
    checkOutput("reset req_ready", 32'(req_ready_o), 32'd1);
    checkOutput("reset cyc", 32'(cyc_o), 32'd0);
    checkOutput("reset stb", 32'(stb_o), 32'd0);
    checkOutput("reset rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("reset rsp_err", 32'(rsp_err_o), 32'd0);
    checkOutput("reset rsp_rdata", rsp_rdata_o, 32'd0);
    checkOutput("reset adr/sel/we", {adr_o[27:0], sel_o}, {28'd0, 4'd0});
    checkOutput("reset dat", dat_o, 32'd0);
    checkOutput("reset we", 32'(we_o), 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    access_t a;
    logic [1:0] sz;
    logic [31:0] expRd, expD;
    logic [3:0] expS;
    bit e;
    int n;

    vecs.push_back(mkVec(mkAcc(0, 1, 2, 0, 32'h01234567, 0, 0, 0), 0, 32'h0,        4'hF, 32'h01234567));
    vecs.push_back(mkVec(mkAcc(0, 0, 2, 0, 0, 0, 0, 0),            0, 32'h01234567, 4'hF, 32'h0));
    vecs.push_back(mkVec(mkAcc(0, 0, 0, 0, 0, 0, 0, 0),            0, 32'h00000067, 4'h1, 32'h0));
    vecs.push_back(mkVec(mkAcc(1, 0, 0, 0, 0, 0, 0, 0),            0, 32'h00000045, 4'h2, 32'h0));
    vecs.push_back(mkVec(mkAcc(2, 0, 0, 0, 0, 0, 0, 0),            0, 32'h00000023, 4'h4, 32'h0));
    vecs.push_back(mkVec(mkAcc(3, 0, 0, 0, 0, 0, 0, 0),            0, 32'h00000001, 4'h8, 32'h0));
    vecs.push_back(mkVec(mkAcc(4, 1, 0, 0, 32'h12345680, 0, 0, 1), 0, 32'h0,        4'h1, 32'h80808080));
    vecs.push_back(mkVec(mkAcc(4, 0, 0, 1, 0, 0, 0, 0),            0, 32'h00000080, 4'h1, 32'h0));
    vecs.push_back(mkVec(mkAcc(4, 0, 0, 0, 0, 0, 0, 0),            0, 32'hFFFFFF80, 4'h1, 32'h0));
    vecs.push_back(mkVec(mkAcc(2, 1, 1, 0, 32'h1234BEEF, 0, 0, 0), 0, 32'h0,        4'hC, 32'hBEEFBEEF));
    vecs.push_back(mkVec(mkAcc(1, 0, 1, 0, 0, 0, 0, 0),            1, 32'h0,        4'h0, 32'h0));
    vecs.push_back(mkVec(mkAcc(2, 0, 1, 0, 0, 0, 0, 0),            0, 32'hFFFFBEEF, 4'hC, 32'h0));
    vecs.push_back(mkVec(mkAcc(2, 0, 1, 1, 0, 0, 0, 1),            0, 32'h0000BEEF, 4'hC, 32'h0));
    vecs.push_back(mkVec(mkAcc(0, 0, 2, 0, 0, 2, 0, 0),            0, 32'hBEEF4567, 4'hF, 32'h0));
    vecs.push_back(mkVec(mkAcc(0, 0, 2, 0, 0, 4, 0, 0),            1, 32'h0,        4'hF, 32'h0));
    vecs.push_back(mkVec(mkAcc(8, 1, 2, 0, 32'hAAAA5555, 0, 0, 0), 0, 32'h0,        4'hF, 32'hAAAA5555));
    vecs.push_back(mkVec(mkAcc(8, 1, 2, 0, 32'hCAFEF00D, 0, 1, 0), 1, 32'h0,        4'hF, 32'hCAFEF00D));
    vecs.push_back(mkVec(mkAcc(8, 0, 2, 0, 0, 0, 0, 2),            0, 32'hAAAA5555, 4'hF, 32'h0));
    vecs.push_back(mkVec(mkAcc(0, 0, 3, 0, 0, 0, 0, 0),            1, 32'h0,        4'h0, 32'h0));
    vecs.push_back(mkVec(mkAcc(2, 0, 2, 0, 0, 0, 0, 0),            1, 32'h0,        4'h0, 32'h0));
    vecs.push_back(mkVec(mkAcc(6, 1, 1, 0, 32'h00007FFF, 3, 0, 1), 0, 32'h0,        4'hC, 32'h7FFF7FFF));
    vecs.push_back(mkVec(mkAcc(6, 0, 1, 0, 0, 0, 0, 0),            0, 32'h00007FFF, 4'hC, 32'h0));
    vecs.push_back(mkVec(mkAcc(4, 0, 2, 0, 0, 0, 0, 0),            0, 32'h7FFF0080, 4'hF, 32'h0));

    for (int i = 0; i < 16; i++) busMem[i] = 32'h0;
    for (int i = 0; i < 64; i++) refMem[i] = 8'h0;
    rst_ni = 0; req_valid_i = 0; req_addr_i = 0; req_we_i = 0; req_size_i = 0;
    req_unsigned_i = 0; req_wdata_i = 0; dat_i = 0; ack_i = 0; err_i = 0; rty_i = 0;
    repeat (3) @(negedge clk_i);
    checkReset();
    rst_ni = 1;
    @(negedge clk_i);

    foreach (vecs[i])
      runOne($sformatf("vec%0d", i), vecs[i].acc, vecs[i].expErr, vecs[i].expRdata,
             vecs[i].expSel, vecs[i].expDat);

    ack_i = 1; err_i = 1; rty_i = 1;
    @(negedge clk_i);
    checkOutput("idle terminations ignored rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("idle terminations ignored cyc", 32'(cyc_o), 32'd0);
    ack_i = 0; err_i = 0; rty_i = 0;
    @(negedge clk_i);
    checkOutput("idle terminations ignored rsp_valid later", 32'(rsp_valid_o), 32'd0);

    req_valid_i = 1; req_addr_i = 0; req_we_i = 0; req_size_i = 2; req_unsigned_i = 0;
    @(posedge clk_i); #1;
    req_valid_i = 0;
    @(negedge clk_i);
    checkOutput("midbus cyc before reset", 32'(cyc_o), 32'd1);
    #2 rst_ni = 0;
    #1;
    checkOutput("midbus reset cyc", 32'(cyc_o), 32'd0);
    checkOutput("midbus reset stb", 32'(stb_o), 32'd0);
    checkOutput("midbus reset rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("midbus reset req_ready", 32'(req_ready_o), 32'd1);
    @(negedge clk_i);
    checkOutput("midbus reset held rsp_valid", 32'(rsp_valid_o), 32'd0);
    rst_ni = 1;
    @(negedge clk_i);
    checkOutput("after reset rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("after reset cyc", 32'(cyc_o), 32'd0);

`ifdef WB_MASTER_TIMEOUT_EN
    req_valid_i = 1; req_addr_i = 0; req_we_i = 0; req_size_i = 2;
    @(posedge clk_i); #1;
    req_valid_i = 0;
    n = 0;
    while (!rsp_valid_o && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("timeout latency", 32'(n), 32'd17);
    checkOutput("timeout rsp_err", 32'(rsp_err_o), 32'd1);
    checkOutput("timeout cyc dropped", 32'(cyc_o), 32'd0);
    checkOutput("timeout req_ready", 32'(req_ready_o), 32'd1);
`endif

    for (int k = 0; k < 48; k++) begin
      sz = ($urandom_range(0, 15) < 5) ? 2'd0 : 2'd1;
      n = $urandom_range(0, 15);
      sz = (n < 5) ? 2'd0 : (n < 10) ? 2'd1 : (n < 15) ? 2'd2 : 2'd3;
      a = mkAcc($urandom_range(0, 63), $urandom_range(0, 1) == 1, sz, $urandom_range(0, 1) == 1,
                $urandom, ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 4),
                $urandom_range(0, 7) == 0, $urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) a.addr = a.addr - (a.addr % nBytes(sz));
      e = isBad(a) || a.doErr || (a.nRty > MaxRetries);
      expRd = (e || a.we) ? 32'h0 : refLoad(a);
      expS = (sz == 2'd0) ? 4'(1 << (a.addr % 4)) : (sz == 2'd1) ? 4'(3 << (a.addr % 4)) : 4'hF;
      expD = (sz == 2'd0) ? (a.wdata % 256) * 32'h01010101 :
             (sz == 2'd1) ? (a.wdata % 65536) * 32'h00010001 : a.wdata;
      runOne($sformatf("rand%0d", k), a, e, expRd, expS, expD);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
